// File: rtl/mem8x16_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : mem8x16_arb_if
// Purpose : Requester-side bus of the 8x16 memory arbiter: two single-word
//           command ports plus the memory fill (init) control.
// Rev     : 1.0  initial release
// ============================================================================
interface mem8x16_arb_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [AW-1:0]     addr0;
    logic [AW-1:0]     addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              init_req;
    logic [DATA_W-1:0] init_val;
    logic              init_busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, init_req, init_val,
        input  ack0, ack1, rdata0, rdata1, init_busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, init_req, init_val,
        output ack0, ack1, rdata0, rdata1, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/mem8x16_arb.sv
`default_nettype none
// ============================================================================
// Module  : mem8x16_arb
// Purpose : Round-robin two-requester sequencer and fill engine in front of
//           an 8x16 DFF memory; memory strobes launch on the falling edge.
// Rev     : 1.0  initial release
// ============================================================================
module mem8x16_arb #(
    parameter int DATA_W = 16,
    parameter int AW     = 3,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    mem8x16_arb_if.slave      bus,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    localparam logic [AW-1:0] c_LAST = {AW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_INIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;          // 1 = port 1 wins a tie
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] ival_q, ival_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              cwe_q, cwe_d;
    logic [AW-1:0]     caddr_q, caddr_d;
    logic [DATA_W-1:0] cwdata_q, cwdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              w_grant1;
    logic              w_init_start;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        pend_d       = pend_q;
        ival_d       = ival_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        cwe_d        = cwe_q;
        caddr_d      = caddr_q;
        cwdata_d     = cwdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        busy_d       = busy_q;
        w_grant1     = bus.req1 & (~bus.req0 | rr_q);
        w_init_start = (state_q == ST_IDLE) && pend_q;

        // A fill request landing on the edge that starts a fill is absorbed by it.
        if (bus.init_req && (state_q != ST_INIT) && !w_init_start) begin
            pend_d = 1'b1;
            ival_d = bus.init_val;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_init_start) begin
                    state_d = ST_INIT;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (bus.req0 || bus.req1) begin
                    state_d  = ST_ACCESS;
                    sel_d    = w_grant1;
                    cwe_d    = w_grant1 ? bus.we1    : bus.we0;
                    caddr_d  = w_grant1 ? bus.addr1  : bus.addr0;
                    cwdata_d = w_grant1 ? bus.wdata1 : bus.wdata0;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                rr_d    = ~sel_q;
                if (sel_q) begin
                    ack1_d = 1'b1;
                    if (!cwe_q) rdata1_d = mem_dout;
                end else begin
                    ack0_d = 1'b1;
                    if (!cwe_q) rdata0_d = mem_dout;
                end
            end
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == c_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_cs_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            ST_ACCESS: begin
                mem_cs_d   = 1'b1;
                mem_we_d   = cwe_q;
                mem_addr_d = MEM_AW'(caddr_q);
                mem_din_d  = cwdata_q;
            end
            ST_INIT: begin
                mem_cs_d   = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = MEM_AW'(cnt_q);
                mem_din_d  = ival_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            pend_q   <= 1'b0;
            ival_q   <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            cwe_q    <= 1'b0;
            caddr_q  <= '0;
            cwdata_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            pend_q   <= pend_d;
            ival_q   <= ival_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            cwe_q    <= cwe_d;
            caddr_q  <= caddr_d;
            cwdata_q <= cwdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    // Falling-edge launch keeps the strobes stable across the whole high phase.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.init_busy = busy_q;
    assign mem_cs        = mem_cs_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_din       = mem_din_q;
endmodule
`default_nettype wire

// File: tb/tb_mem8x16_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem8x16_arb
// Purpose : Self-checking bench for mem8x16_arb with a behavioural 8x16 memory.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem8x16_arb;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int MAW = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mem_cs, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_din, mem_dout;
    logic [DW-1:0]  mem_arr [8];
    int             n_checks = 0;
    int             n_pass   = 0;

    mem8x16_arb_if #(.DATA_W(DW), .AW(AW)) bus ();

    mem8x16_arb #(.DATA_W(DW), .AW(AW), .MEM_AW(MAW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory macro stand-in: combinational read, write on rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem_arr[i] <= '0;
        end else if (mem_cs && mem_we) begin
            mem_arr[mem_addr[2:0]] <= mem_din;
        end
    end
    assign mem_dout = mem_arr[mem_addr[2:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---------------- behavioural model (edge-number arithmetic) ----------------
    int            cyc, next_free, init_start, g_edge, g_port;
    bit            g_we, m_pend, m_rr;
    logic [2:0]    g_addr;
    logic [DW-1:0] g_wdata, m_pval, m_ival;
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] e_rd0, e_rd1, e_din;
    bit            e_ack0, e_ack1, e_busy, e_cs, e_we;
    logic [2:0]    e_addr;

    task automatic model_reset();
        cyc = 0; next_free = 0; init_start = -100; g_edge = -100; g_port = 0;
        g_we = 0; g_addr = '0; g_wdata = '0; m_pend = 0; m_rr = 0;
        m_pval = '0; m_ival = '0; e_rd0 = '0; e_rd1 = '0; e_din = '0;
        e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_cs = 0; e_we = 0; e_addr = '0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    endtask

    task automatic model_step();
        bit started;
        int n;
        started = 0;
        cyc++;
        n = cyc;
        e_ack0 = 0;
        e_ack1 = 0;
        if (g_edge == n - 1) begin
            if (g_port == 0) e_ack0 = 1; else e_ack1 = 1;
            if (g_we) ref_mem[g_addr] = g_wdata;
            else if (g_port == 0) e_rd0 = ref_mem[g_addr];
            else e_rd1 = ref_mem[g_addr];
        end
        if (n >= next_free) begin
            if (m_pend) begin
                init_start = n; m_pend = 0; started = 1; next_free = n + 9; m_ival = m_pval;
                for (int i = 0; i < 8; i++) ref_mem[i] = m_pval;
            end else if (bus.req0 || bus.req1) begin
                g_port  = (bus.req0 && bus.req1) ? int'(m_rr) : (bus.req1 ? 1 : 0);
                g_edge  = n;
                g_we    = (g_port == 1) ? bus.we1 : bus.we0;
                g_addr  = (g_port == 1) ? bus.addr1 : bus.addr0;
                g_wdata = (g_port == 1) ? bus.wdata1 : bus.wdata0;
                m_rr    = (g_port == 0);
                next_free = n + 2;
            end
        end
        if (bus.init_req && !started && !(n >= init_start + 1 && n <= init_start + 8)) begin
            m_pend = 1;
            m_pval = bus.init_val;
        end
        e_busy = (n >= init_start) && (n <= init_start + 7);
        e_cs = 0;
        if (g_edge == n) begin
            e_cs = 1; e_we = g_we; e_addr = g_addr; e_din = g_wdata;
        end else if (e_busy) begin
            e_cs = 1; e_we = 1; e_addr = 3'(n - init_start); e_din = m_ival;
        end
    endtask

    initial begin : compare
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset(); else model_step();
            #1;
            if (rst) model_reset();
            chk("ack0",      32'(bus.ack0),      32'(e_ack0));
            chk("ack1",      32'(bus.ack1),      32'(e_ack1));
            chk("rdata0",    32'(bus.rdata0),    32'(e_rd0));
            chk("rdata1",    32'(bus.rdata1),    32'(e_rd1));
            chk("init_busy", 32'(bus.init_busy), 32'(e_busy));
            @(negedge clk);
            #1;
            if (rst) model_reset();
            chk("mem_cs", 32'(mem_cs), 32'(e_cs));
            chk("mem_addr_range", 32'(mem_addr[MAW-1:3]), 32'd0);
            if (e_cs) begin
                chk("mem_we",   32'(mem_we),   32'(e_we));
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_din",  32'(mem_din),  32'(e_din));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_access(input int p, input bit w, input logic [2:0] a, input logic [DW-1:0] d,
                             output logic [DW-1:0] rd, output int lat);
        bit done;
        done = 0;
        lat  = 0;
        if (p == 0) begin bus.req0 = 1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
        else        begin bus.req1 = 1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
        for (int i = 0; i < 40 && !done; i++) begin
            tick(1);
            lat++;
            if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) done = 1;
        end
        if (p == 0) bus.req0 = 0; else bus.req1 = 0;
        chk("ack_seen", 32'(done), 32'd1);
        rd = (p == 0) ? bus.rdata0 : bus.rdata1;
    endtask

    initial begin : stim
        logic [DW-1:0] rd;
        int            lat, busy_cnt, bad;
        bit            got;
        int            ack_port[$];
        int            ack_t[$];

        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.init_req = 0; bus.init_val = '0;

        tick(3);
        chk("rst_ack0",   32'(bus.ack0),      32'd0);
        chk("rst_ack1",   32'(bus.ack1),      32'd0);
        chk("rst_rdata0", 32'(bus.rdata0),    32'd0);
        chk("rst_rdata1", 32'(bus.rdata1),    32'd0);
        chk("rst_busy",   32'(bus.init_busy), 32'd0);
        chk("rst_cs",     32'(mem_cs),        32'd0);
        chk("rst_we",     32'(mem_we),        32'd0);
        chk("rst_addr",   32'(mem_addr),      32'd0);
        chk("rst_din",    32'(mem_din),       32'd0);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("idle_cs", 32'(mem_cs), 32'd0);
        end

        do_access(0, 1, 3'd3, 16'hA5C3, rd, lat);
        chk("write_latency", 32'(lat), 32'd2);
        do_access(0, 0, 3'd3, 16'h0000, rd, lat);
        chk("read0_addr3", 32'(rd), 32'h0000A5C3);
        do_access(1, 0, 3'd3, 16'h0000, rd, lat);
        chk("read1_addr3", 32'(rd), 32'h0000A5C3);
        do_access(1, 1, 3'd7, 16'h0F0F, rd, lat);
        do_access(0, 0, 3'd7, 16'h0000, rd, lat);
        chk("read0_addr7", 32'(rd), 32'h00000F0F);

        // Contention from a fresh reset so the tie goes to port 0 first.
        rst = 1; tick(1); rst = 0;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3'd1; bus.wdata0 = 16'h1111;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 3'd2; bus.wdata1 = 16'h2222;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (bus.ack0) begin ack_port.push_back(0); ack_t.push_back(i); end
            if (bus.ack1) begin ack_port.push_back(1); ack_t.push_back(i); end
        end
        bus.req0 = 0; bus.req1 = 0;
        tick(3);
        chk("contention_acks", 32'(ack_port.size()), 32'd8);
        if (ack_port.size() >= 4) begin
            chk("grant_order0", 32'(ack_port[0]), 32'd0);
            chk("grant_order1", 32'(ack_port[1]), 32'd1);
            chk("grant_order2", 32'(ack_port[2]), 32'd0);
            chk("grant_order3", 32'(ack_port[3]), 32'd1);
            chk("rr_period",    32'(ack_t[2] - ack_t[0]), 32'd4);
        end
        do_access(0, 0, 3'd1, 16'h0000, rd, lat);
        chk("read_addr1", 32'(rd), 32'h00001111);
        do_access(1, 0, 3'd2, 16'h0000, rd, lat);
        chk("read_addr2", 32'(rd), 32'h00002222);

        // Fill, with a port-1 read raised while the fill runs.
        bus.init_req = 1; bus.init_val = 16'hBEEF;
        tick(1);
        bus.init_req = 0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3'd5;
        busy_cnt = 0; bad = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick(1);
            if (bus.init_busy) busy_cnt++;
            if (bus.ack1) begin
                got = 1;
                if (busy_cnt != 8) bad = 1;
            end
        end
        bus.req1 = 0;
        chk("init_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("init_holds_req1",  32'(bad),      32'd0);
        chk("init_req1_acked",  32'(got),      32'd1);
        chk("init_req1_rdata",  32'(bus.rdata1), 32'h0000BEEF);
        for (int a = 0; a < 8; a++) begin
            do_access(0, 0, 3'(a), 16'h0000, rd, lat);
            chk("fill_read", 32'(rd), 32'h0000BEEF);
        end

        // Fill requested during the ACCESS cycle of a write.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3'd6; bus.wdata0 = 16'h1234;
        tick(1);
        bus.init_req = 1; bus.init_val = 16'h5A5A;
        tick(1);
        chk("iacc_ack0", 32'(bus.ack0),      32'd1);
        chk("iacc_busy", 32'(bus.init_busy), 32'd0);
        bus.req0 = 0; bus.init_req = 0;
        tick(1);
        chk("iacc_busy_next", 32'(bus.init_busy), 32'd1);
        for (int i = 0; i < 20 && bus.init_busy; i++) tick(1);
        chk("iacc_busy_done", 32'(bus.init_busy), 32'd0);
        do_access(0, 0, 3'd6, 16'h0000, rd, lat);
        chk("iacc_read6", 32'(rd), 32'h00005A5A);

        // Reset while the fill counter sits at 4.
        bus.init_req = 1; bus.init_val = 16'h7777;
        tick(1);
        bus.init_req = 0;
        tick(1);
        chk("rinit_busy_on", 32'(bus.init_busy), 32'd1);
        tick(4);
        #1 rst = 1;
        #1;
        chk("rinit_busy_off", 32'(bus.init_busy), 32'd0);
        chk("rinit_cs_off",   32'(mem_cs),        32'd0);
        @(posedge clk);
        #2 rst = 0;
        tick(1);
        for (int a = 0; a < 8; a++) begin
            do_access(1, 0, 3'(a), 16'h0000, rd, lat);
            chk("rinit_read0", 32'(rd), 32'd0);
        end

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
